ser2par_stream: RTL and testbench
=================================

SER2PAR_STREAM -- requirements
Module: ser2par_stream

Interface
REQ-001 Parameter WORD_SIZE, default 8: bits per output word.
REQ-002 Parameter LANES, default 1: serial bits accepted per beat; WORD_SIZE SHALL be an integer multiple of LANES.
REQ-003 Parameter FIFO_DEPTH, default 2: output word buffer depth; SHALL be a power of two, >= 2.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  serial_in/lsb_in carry a beat this cycle.
REQ-008 serial_in  input  LANES  beat data; bit LANES-1 is most significant within the beat.
REQ-009 lsb_in  input  1  marks the beat holding the word's LSB (final beat); meaningful only with in_valid.
REQ-010 out_ready  input  1  consumer accepts parallel_out this cycle.
REQ-011 parallel_out  output  WORD_SIZE  head-of-buffer word.
REQ-012 valid  output  1  parallel_out holds an unconsumed word.
REQ-013 frame_err  output  1  one-cycle pulse on framing error.
REQ-014 overflow  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-015 Word is MSB-first: BEATS = WORD_SIZE/LANES beats; each beat shifts left by LANES, serial_in entering the low LANES bits.
REQ-016 Beat counter counts 0..BEATS-1; advances only on in_valid; idle cycles hold all state.
REQ-017 States: SHIFT (assembling) and HUNT (resynchronising); reset state SHIFT, count 0.
REQ-018 SHIFT, in_valid, lsb_in=1, count=BEATS-1: word complete; push to buffer; count -> 0.
REQ-019 SHIFT, in_valid, lsb_in=1, count<BEATS-1: frame_err pulse next cycle; partial word discarded; count -> 0; remain SHIFT.
REQ-020 SHIFT, in_valid, lsb_in=0, count=BEATS-1: frame_err pulse next cycle; word discarded; enter HUNT.
REQ-021 HUNT: all beats discarded; beat with in_valid and lsb_in=1 returns to SHIFT, count 0; that beat is also discarded.
REQ-022 No backpressure on input: input beats are always consumed.
REQ-023 Latency: completed word appears at parallel_out with valid=1 the cycle after its final beat if buffer was empty.
REQ-024 Pop occurs when valid and out_ready; parallel_out/valid SHALL be stable while valid=1 and out_ready=0.
REQ-025 Push when buffer full and no pop same cycle: word dropped, overflow pulse next cycle, buffer unchanged.
REQ-026 Push and pop in same cycle when full: both occur, no overflow.
REQ-027 Push and pop same cycle when holding one word: occupancy unchanged, new word becomes head next cycle.
REQ-028 Buffer order strictly FIFO; pointer wrap-around SHALL not lose or duplicate words.
REQ-029 frame_err and overflow are registered, never asserted two consecutive cycles for one event.

Reset
REQ-030 Reset asserted: parallel_out=0, valid=0, frame_err=0, overflow=0, state SHIFT, count 0, buffer empty, shift register 0.
REQ-031 Reset mid-word or with buffered words: all partial and buffered data discarded immediately, no pulse generated.
REQ-032 First beat after reset deassertion is treated as beat 0 of a new word.

Structure
REQ-033 State encoding (SHIFT, HUNT) and the BEATS derivation SHALL live in shared package/include ser2par_pkg.
REQ-034 Output buffer SHALL be sub-module ser2par_fifo (WIDTH, DEPTH; push, pop, full, empty, head data).
REQ-035 Top module holds shifter, beat counter, state machine and status pulses only.

Verification
REQ-036 WORD_SIZE=8, LANES=1: beats 1,0,1,0,0,1,0,1, lsb_in on last, out_ready=1 -> parallel_out=8'hA5, valid=1 one cycle after last beat, one cycle only.
REQ-037 LANES=2: beats 2'b11,2'b00,2'b10,2'b01, lsb_in on 4th -> parallel_out=8'hC9.
REQ-038 LANES=1: lsb_in on 5th beat -> frame_err pulse, no word; following clean 8'h3C word -> 8'h3C output.
REQ-039 LANES=1: 8 beats without lsb_in -> frame_err, HUNT; next 3 beats discarded until lsb_in beat; following word 8'h81 -> 8'h81.
REQ-040 FIFO_DEPTH=2, out_ready=0: words 8'h11, 8'h22, 8'h33 -> overflow pulse on third; then out_ready=1 -> 8'h11, 8'h22 only.
REQ-041 Reset asserted after 4 beats with one buffered word -> valid=0 immediately; next 8-beat word 8'hF0 -> 8'hF0 output.

Source files
------------

// File: rtl/ser2par_pkg.sv
// Shared definitions for the serial-to-parallel stream converter:
// assembler state encoding and beats-per-word derivation.
package ser2par_pkg;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_HUNT  = 1'b1
  } state_t;

  function automatic int calc_beats(input int word_size, input int lanes);
    return word_size / lanes;
  endfunction

endpackage

// File: rtl/ser2par_fifo.sv
// Power-of-two word buffer; head is visible the cycle after the push that filled it.
// A push into a full buffer is accepted only when a pop frees a slot the same cycle.
module ser2par_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ser2par_stream.sv
// MSB-first serial-to-parallel assembler; a word is at parallel_out the cycle after its lsb beat.
// Input is never stalled; a word completing into a full buffer is dropped and flagged via overflow.
module ser2par_stream
  import ser2par_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [LANES-1:0]     serial_in,
  input  logic                 lsb_in,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] parallel_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int BEATS = calc_beats(WORD_SIZE, LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = (BEATS > 1) ? (WORD_SIZE - LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t               state;
  logic [CW-1:0]        count;
  logic [SW-1:0]        shreg;
  logic [WORD_SIZE-1:0] next_word;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  // Only the bits still needed for the current word are kept between beats.
  if (BEATS > 1) begin : g_multi
    assign next_word = {shreg, serial_in};
  end else begin : g_single
    assign next_word = serial_in;
  end

  assign push  = in_valid && (state == ST_SHIFT) && lsb_in && (count == LAST);
  assign valid = !empty;
  assign pop   = valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SHIFT;
      count     <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= push && full && !pop;
      if (in_valid) begin
        case (state)
          ST_SHIFT: begin
            if (lsb_in) begin
              count <= '0;
              shreg <= '0;
              if (count != LAST) frame_err <= 1'b1;
            end else if (count == LAST) begin
              frame_err <= 1'b1;
              state     <= ST_HUNT;
              count     <= '0;
              shreg     <= '0;
            end else begin
              count <= count + 1'b1;
              shreg <= next_word[SW-1:0];
            end
          end
          ST_HUNT: begin
            if (lsb_in) state <= ST_SHIFT;
          end
          default: state <= ST_SHIFT;
        endcase
      end
    end
  end

  ser2par_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (next_word),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (parallel_out)
  );

endmodule

// File: tb/tb_ser2par_stream.sv
// Two instances (1 lane / depth 2, 2 lanes / depth 4) checked every cycle against a word-level model.
module tb_ser2par_stream;

  logic       clk = 1'b0;
  logic       reset;
  always #5 clk = ~clk;

  logic       a_iv, a_lsb, a_rdy, a_vld, a_fe, a_ov;
  logic [0:0] a_d;
  logic [7:0] a_po;
  logic       b_iv, b_lsb, b_rdy, b_vld, b_fe, b_ov;
  logic [1:0] b_d;
  logic [7:0] b_po;

  ser2par_stream #(.WORD_SIZE(8), .LANES(1), .FIFO_DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_iv), .serial_in(a_d), .lsb_in(a_lsb),
    .out_ready(a_rdy), .parallel_out(a_po), .valid(a_vld), .frame_err(a_fe), .overflow(a_ov)
  );

  ser2par_stream #(.WORD_SIZE(8), .LANES(2), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_iv), .serial_in(b_d), .lsb_in(b_lsb),
    .out_ready(b_rdy), .parallel_out(b_po), .valid(b_vld), .frame_err(b_fe), .overflow(b_ov)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Word-level reference: beats collected so far, hunt flag, and a plain array as the buffer.
  int         lanes_of [2] = '{1, 2};
  int         depth_of [2] = '{2, 4};
  int         m_n   [2];
  bit         m_hunt[2];
  logic [7:0] m_acc [2];
  logic [7:0] m_q   [2][4];
  int         m_cnt [2];
  bit         m_fe  [2];
  bit         m_ov  [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_hunt[i] = 0; m_acc[i] = '0; m_cnt[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
    end
  endtask

  task automatic model_step(input int ix, input bit iv, input logic [1:0] d, input bit lsb, input bit rdy);
    int beats;
    bit done;
    bit pop;
    beats     = 8 / lanes_of[ix];
    done      = 0;
    m_fe[ix]  = 0;
    m_ov[ix]  = 0;
    pop       = (m_cnt[ix] > 0) && rdy;
    if (iv) begin
      if (m_hunt[ix]) begin
        if (lsb) begin m_hunt[ix] = 0; m_n[ix] = 0; end
      end else begin
        m_acc[ix] = 8'((int'(m_acc[ix]) << lanes_of[ix]) | int'(d));
        m_n[ix]++;
        if (lsb) begin
          if (m_n[ix] == beats) done = 1;
          else m_fe[ix] = 1;
          m_n[ix] = 0;
        end else if (m_n[ix] == beats) begin
          m_fe[ix] = 1; m_hunt[ix] = 1; m_n[ix] = 0;
        end
      end
    end
    if (pop) begin
      for (int k = 0; k < 3; k++) m_q[ix][k] = m_q[ix][k+1];
      m_cnt[ix]--;
    end
    if (done) begin
      if (m_cnt[ix] < depth_of[ix]) begin
        m_q[ix][m_cnt[ix]] = m_acc[ix];
        m_cnt[ix]++;
      end else m_ov[ix] = 1;
    end
  endtask

  task automatic check_outputs();
    check("a_vld", a_vld, m_cnt[0] > 0);
    check("a_dat", a_po, (m_cnt[0] > 0) ? m_q[0][0] : 8'h00);
    check("a_fe",  a_fe,  m_fe[0]);
    check("a_ov",  a_ov,  m_ov[0]);
    check("b_vld", b_vld, m_cnt[1] > 0);
    check("b_dat", b_po, (m_cnt[1] > 0) ? m_q[1][0] : 8'h00);
    check("b_fe",  b_fe,  m_fe[1]);
    check("b_ov",  b_ov,  m_ov[1]);
  endtask

  // Called at a falling edge: check, drive the next beat, advance the model, move to the next falling edge.
  task automatic cycle(input bit aiv, input bit ad, input bit alsb,
                       input bit biv, input logic [1:0] bd, input bit blsb);
    check_outputs();
    a_iv = aiv; a_d = ad; a_lsb = alsb;
    b_iv = biv; b_d = bd; b_lsb = blsb;
    model_step(0, aiv, {1'b0, ad}, alsb, a_rdy);
    model_step(1, biv, bd, blsb, b_rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2'b00, 0);
  endtask

  task automatic send_a(input logic [15:0] pat, input int len, input bit lsb_last);
    logic [15:0] p;
    p = pat;
    for (int i = len - 1; i >= 0; i--) cycle(1, p[i], (i == 0) && lsb_last, 0, 2'b00, 0);
  endtask

  task automatic do_reset();
    a_iv = 0; a_lsb = 0; a_d = '0; b_iv = 0; b_lsb = 0; b_d = '0;
    reset = 1'b1;
    #1;
    check("rst_a_vld", a_vld, 1'b0);
    check("rst_a_dat", a_po, 8'h00);
    check("rst_b_vld", b_vld, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_iv = 0; a_d = '0; a_lsb = 0; a_rdy = 1;
    b_iv = 0; b_d = '0; b_lsb = 0; b_rdy = 1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("init_a_vld", a_vld, 1'b0);
    check("init_a_fe",  a_fe,  1'b0);
    check("init_b_dat", b_po,  8'h00);
    reset = 1'b0;

    send_a(16'h00A5, 8, 1);
    check("a5_vld", a_vld, 1'b1);
    check("a5_dat", a_po, 8'hA5);
    idle(1);
    check("a5_once", a_vld, 1'b0);

    cycle(0, 0, 0, 1, 2'b11, 0);
    cycle(0, 0, 0, 1, 2'b00, 0);
    cycle(0, 0, 0, 1, 2'b10, 0);
    cycle(0, 0, 0, 1, 2'b01, 1);
    check("c9_dat", b_po, 8'hC9);
    idle(1);

    send_a(16'b10110, 5, 1);
    check("short_fe", a_fe, 1'b1);
    check("short_vld", a_vld, 1'b0);
    idle(1);
    check("short_fe_once", a_fe, 1'b0);
    send_a(16'h003C, 8, 1);
    check("3c_dat", a_po, 8'h3C);
    idle(1);

    send_a(16'h0055, 8, 0);
    check("long_fe", a_fe, 1'b1);
    send_a(16'b101, 3, 0);
    send_a(16'b1, 1, 1);
    check("hunt_vld", a_vld, 1'b0);
    send_a(16'h0081, 8, 1);
    check("81_dat", a_po, 8'h81);
    idle(1);

    a_rdy = 0;
    send_a(16'h0011, 8, 1);
    send_a(16'h0022, 8, 1);
    send_a(16'h0033, 8, 1);
    check("ovf_pulse", a_ov, 1'b1);
    check("ovf_head", a_po, 8'h11);
    idle(1);
    check("ovf_once", a_ov, 1'b0);
    a_rdy = 1;
    idle(1);
    check("pop_22", a_po, 8'h22);
    idle(1);
    check("pop_done", a_vld, 1'b0);

    a_rdy = 0;
    send_a(16'h0077, 8, 1);
    send_a(16'h000F, 4, 0);
    do_reset();
    a_rdy = 1;
    send_a(16'h00F0, 8, 1);
    check("f0_dat", a_po, 8'hF0);
    idle(1);

    for (int c = 0; c < 3000; c++) begin
      bit slow;
      slow  = ((c / 200) % 2) == 1;
      a_rdy = slow ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      b_rdy = slow ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      if (c == 1500) do_reset();
      else cycle($urandom % 4 != 0, 1'($urandom % 2), $urandom % 8 == 0,
                 $urandom % 4 != 0, 2'($urandom % 4), $urandom % 4 == 0);
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
